// File: rtl/cpu_tb_pkg.sv
// Shared types for the host loader: FSM state encoding, byte-address shift and
// the phase-skipping helper used when a session phase has zero length.
package cpu_tb_pkg;

  typedef enum logic [2:0] {
    IDLE,
    LOAD,
    RUN,
    DUMP_REQ,
    DUMP_CAP,
    DUMP_OUT,
    DONE
  } state_t;

  localparam int ADDR_SHIFT = 2;

  // Picks the earliest phase that still has work, in session order.
  function automatic state_t first_phase(input logic has_load,
                                         input logic has_run,
                                         input logic has_dump);
    if (has_load) return LOAD;
    if (has_run)  return RUN;
    if (has_dump) return DUMP_REQ;
    return DONE;
  endfunction

endpackage

// File: rtl/loader_counter.sv
// Loadable up-counter; tc flags the final count (count == term-1) of a run of
// term steps. tc is only meaningful while term is non-zero.
module loader_counter #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         load,
  input  logic [W-1:0] load_value,
  input  logic         inc,
  input  logic [W-1:0] term,
  output logic [W-1:0] count,
  output logic         tc
);

  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // pre-edge values regardless of block ordering.
  always_ff @(posedge clk) begin
    if (rst)       count <= '0;
    else if (load) count <= load_value;
    else if (inc)  count <= count + 1'b1;
  end

  assign tc = (count == term - 1'b1);

endmodule

// File: rtl/cpu_host_loader.sv
// Host-side session sequencer: streams a program into IMEM, runs the CPU for a
// fixed cycle count, then streams DMEM back out. Optional LOADER_CHECKSUM_EN.
module cpu_host_loader
  import cpu_tb_pkg::*;
#(
  parameter int IMEM_AW = 9,
  parameter int DMEM_AW = 10
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  output logic               busy,
  output logic               done,
  input  logic [IMEM_AW:0]   prog_len,
  input  logic [31:0]        run_cycles,
  input  logic [DMEM_AW:0]   dump_len,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [31:0]        in_data,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [31:0]        out_data,
  output logic               cpu_enable,
  output logic [31:0]        addr_ext,
  output logic [31:0]        wdata_ext,
  output logic               wen_ext,
  output logic               ren_ext,
  input  logic [31:0]        rdata_ext,
  output logic [31:0]        addr_ext_2,
  output logic [31:0]        wdata_ext_2,
  output logic               wen_ext_2,
  output logic               ren_ext_2,
  input  logic [31:0]        rdata_ext_2
`ifdef LOADER_CHECKSUM_EN
  ,
  output logic [31:0]        checksum
`endif
);

  localparam int CW = ((IMEM_AW > DMEM_AW) ? IMEM_AW : DMEM_AW) + 1;

  state_t            state, state_next;
  logic [IMEM_AW:0]  prog_len_r;
  logic [31:0]       run_cycles_r;
  logic [DMEM_AW:0]  dump_len_r;
  logic [31:0]       data_q;

  logic [CW-1:0]     word_idx, word_term;
  logic              word_clr, word_inc, word_tc;
  logic [31:0]       cycle_count;
  logic              cycle_clr, cycle_inc, cycle_tc;

  // The loader never reads IMEM; the cycle count itself is only needed for tc.
  logic unused_ok;
  assign unused_ok = ^{rdata_ext, cycle_count};

  assign ren_ext     = 1'b0;
  assign wen_ext_2   = 1'b0;
  assign wdata_ext_2 = '0;

  loader_counter #(.W(CW)) u_word_cnt (
    .clk        (clk),
    .rst        (rst),
    .load       (word_clr),
    .load_value ('0),
    .inc        (word_inc),
    .term       (word_term),
    .count      (word_idx),
    .tc         (word_tc)
  );

  loader_counter #(.W(32)) u_cycle_cnt (
    .clk        (clk),
    .rst        (rst),
    .load       (cycle_clr),
    .load_value ('0),
    .inc        (cycle_inc),
    .term       (run_cycles_r),
    .count      (cycle_count),
    .tc         (cycle_tc)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= IDLE;
      prog_len_r   <= '0;
      run_cycles_r <= '0;
      dump_len_r   <= '0;
      data_q       <= '0;
    end else begin
      state <= state_next;
      if (state == IDLE && start) begin
        prog_len_r   <= prog_len;
        run_cycles_r <= run_cycles;
        dump_len_r   <= dump_len;
      end
      if (state == DUMP_CAP) data_q <= rdata_ext_2;
    end
  end

  // NOTE: every output gets a default before the case so no path leaves a
  // signal unassigned, which would otherwise infer a latch.
  always_comb begin
    state_next = state;
    busy       = 1'b0;
    done       = 1'b0;
    in_ready   = 1'b0;
    out_valid  = 1'b0;
    out_data   = '0;
    cpu_enable = 1'b0;
    addr_ext   = '0;
    wdata_ext  = '0;
    wen_ext    = 1'b0;
    addr_ext_2 = '0;
    ren_ext_2  = 1'b0;
    word_clr   = 1'b0;
    word_inc   = 1'b0;
    cycle_clr  = 1'b0;
    cycle_inc  = 1'b0;
    word_term  = CW'(dump_len_r);

    // Outputs are forced quiet while rst is high so an interrupted load
    // cannot issue one last write on the reset edge.
    if (!rst) begin
      busy = (state != IDLE);
      case (state)
        IDLE: begin
          if (start) begin
            word_clr   = 1'b1;
            cycle_clr  = 1'b1;
            state_next = first_phase(prog_len != '0, run_cycles != '0,
                                     dump_len != '0);
          end
        end
        LOAD: begin
          in_ready  = 1'b1;
          word_term = CW'(prog_len_r);
          if (in_valid) begin
            wen_ext   = 1'b1;
            addr_ext  = 32'(word_idx) << ADDR_SHIFT;
            wdata_ext = in_data;
            word_inc  = 1'b1;
            if (word_tc) begin
              word_clr   = 1'b1;
              state_next = first_phase(1'b0, run_cycles_r != '0,
                                       dump_len_r != '0);
            end
          end
        end
        RUN: begin
          cpu_enable = 1'b1;
          cycle_inc  = 1'b1;
          if (cycle_tc) state_next = first_phase(1'b0, 1'b0, dump_len_r != '0);
        end
        DUMP_REQ: begin
          ren_ext_2  = 1'b1;
          addr_ext_2 = 32'(word_idx) << ADDR_SHIFT;
          state_next = DUMP_CAP;
        end
        DUMP_CAP: state_next = DUMP_OUT;
        DUMP_OUT: begin
          out_valid = 1'b1;
          out_data  = data_q;
          if (out_ready) begin
            word_inc   = 1'b1;
            state_next = word_tc ? DONE : DUMP_REQ;
          end
        end
        DONE: begin
          done       = 1'b1;
          state_next = IDLE;
        end
        default: state_next = IDLE;
      endcase
    end
  end

`ifdef LOADER_CHECKSUM_EN
  always_ff @(posedge clk) begin
    if (rst)                         checksum <= '0;
    else if (state == IDLE && start) checksum <= '0;
    else if (wen_ext)                checksum <= checksum + in_data;
  end
`endif

endmodule

// File: tb/tb_cpu_host_loader.sv
// Scoreboard bench for cpu_host_loader: expected writes and dump words are
// queued as stimulus is issued and retired by a negedge monitor.
module tb_cpu_host_loader;

  logic        clk = 1'b0;
  logic        rst, start;
  logic        busy, done;
  logic [9:0]  prog_len;
  logic [31:0] run_cycles;
  logic [10:0] dump_len;
  logic        in_valid, in_ready;
  logic [31:0] in_data;
  logic        out_valid, out_ready;
  logic [31:0] out_data;
  logic        cpu_enable;
  logic [31:0] addr_ext, wdata_ext, rdata_ext;
  logic        wen_ext, ren_ext;
  logic [31:0] addr_ext_2, wdata_ext_2, rdata_ext_2;
  logic        wen_ext_2, ren_ext_2;
`ifdef LOADER_CHECKSUM_EN
  logic [31:0] checksum;
`endif

  cpu_host_loader #(.IMEM_AW(9), .DMEM_AW(10)) dut (
    .clk         (clk),
    .rst         (rst),
    .start       (start),
    .busy        (busy),
    .done        (done),
    .prog_len    (prog_len),
    .run_cycles  (run_cycles),
    .dump_len    (dump_len),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .in_data     (in_data),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .out_data    (out_data),
    .cpu_enable  (cpu_enable),
    .addr_ext    (addr_ext),
    .wdata_ext   (wdata_ext),
    .wen_ext     (wen_ext),
    .ren_ext     (ren_ext),
    .rdata_ext   (rdata_ext),
    .addr_ext_2  (addr_ext_2),
    .wdata_ext_2 (wdata_ext_2),
    .wen_ext_2   (wen_ext_2),
    .ren_ext_2   (ren_ext_2),
    .rdata_ext_2 (rdata_ext_2)
`ifdef LOADER_CHECKSUM_EN
    ,
    .checksum    (checksum)
`endif
  );

  always #5 clk = ~clk;

  logic [31:0] dmem [1024];
  always @(posedge clk) if (ren_ext_2) rdata_ext_2 <= dmem[addr_ext_2[11:2]];

  int checks = 0;
  int errors = 0;
  logic [63:0] wr_q[$];
  logic [31:0] dump_q[$];
  int wen_total = 0, en_total = 0, done_total = 0, busy_total = 0, hs_total = 0;
  int s_wen, s_en, s_done, s_busy, s_hs;
  logic [31:0] csum_model;
  logic [31:0] words[3] = '{32'h2001_0005, 32'h2002_0007, 32'h0022_1820};

  task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, act, exp, $time);
    end
  endtask

  function automatic logic [9:0] outs_vec();
    return {busy, done, cpu_enable, in_ready, out_valid, wen_ext, ren_ext,
            wen_ext_2, ren_ext_2,
            |{addr_ext, wdata_ext, addr_ext_2, wdata_ext_2, out_data}};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic monitor();
    forever begin
      @(negedge clk);
      if (rst) check("rst_outs", 64'(outs_vec()), 0);
      check("strobe_vs_enable",
            64'(cpu_enable && (wen_ext || ren_ext || wen_ext_2 || ren_ext_2)), 0);
      check("imem_bus_idle", wen_ext ? 64'd0 : {addr_ext, wdata_ext}, 0);
      check("dmem_bus_idle", (ren_ext_2 || wen_ext_2) ? 64'd0 : {addr_ext_2, wdata_ext_2}, 0);
      check("out_data_idle", out_valid ? 64'd0 : 64'(out_data), 0);
      check("ren_ext_tied", 64'(ren_ext), 0);
      if (wen_ext) begin
        wen_total++;
        if (wr_q.size() > 0) check("imem_write", {addr_ext, wdata_ext}, wr_q.pop_front());
        else check("imem_write_extra", 1, 0);
      end
      if (out_valid) begin
        if (dump_q.size() > 0) begin
          check("dump_word", 64'(out_data), 64'(dump_q[0]));
          if (out_ready) begin
            void'(dump_q.pop_front());
            hs_total++;
          end
        end else check("dump_word_extra", 1, 0);
      end
      if (cpu_enable) en_total++;
      if (done) done_total++;
      if (busy) busy_total++;
    end
  endtask

  task automatic snap();
    s_wen = wen_total; s_en = en_total; s_done = done_total;
    s_busy = busy_total; s_hs = hs_total;
  endtask

  task automatic start_session(input logic [9:0] pl, input logic [31:0] rc,
                               input logic [10:0] dl);
    prog_len = pl; run_cycles = rc; dump_len = dl;
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic feed(input logic [31:0] w);
    bit acc;
    int n = 0;
    in_valid = 1'b1;
    in_data  = w;
    do begin
      @(negedge clk);
      acc = in_ready;
      tick();
      n++;
    end while (!acc && n < 50);
    if (!acc) check("feed_timeout", 1, 0);
    in_valid = 1'b0;
  endtask

  task automatic wait_idle(input bit rand_ready, input int budget);
    int n = 0;
    do begin
      if (rand_ready) out_ready = 1'($urandom_range(0, 1));
      tick();
      n++;
    end while (busy && n < budget);
    if (busy) check("idle_timeout", 1, 0);
  endtask

  task automatic load_words(input int n);
    csum_model = 0;
    for (int i = 0; i < n; i++) begin
      wr_q.push_back({32'(i * 4), words[i]});
      csum_model += words[i];
    end
  endtask

  task automatic stimulus();
    logic [31:0] rw[4];
    rst = 1'b1; start = 1'b0; prog_len = '0; run_cycles = '0; dump_len = '0;
    in_valid = 1'b0; in_data = '0; out_ready = 1'b1; rdata_ext = '0;
    for (int i = 0; i < 1024; i++) dmem[i] = 32'(i) ^ 32'hA5A5_0000;
    tick(); tick();
    rst = 1'b0;
    @(negedge clk);
    check("idle_after_reset", 64'(outs_vec()), 0);
    tick();

    // Three-word load with no other phases.
    snap();
    load_words(3);
    start_session(10'd3, 0, 11'd0);
    for (int i = 0; i < 3; i++) feed(words[i]);
    wait_idle(1'b0, 100);
    check("load_writes", 64'(wen_total - s_wen), 3);
    check("load_busy", 64'(busy_total - s_busy), 4);
    check("load_done", 64'(done_total - s_done), 1);
    check("load_queue_drained", 64'(wr_q.size()), 0);
`ifdef LOADER_CHECKSUM_EN
    check("load_checksum", 64'(checksum), 64'(csum_model));
`endif

    // Run for 20 cycles while in_valid is held high and must be ignored.
    snap();
    in_valid = 1'b1; in_data = 32'hDEAD_BEEF;
    start_session(10'd0, 32'd20, 11'd0);
    wait_idle(1'b0, 100);
    in_valid = 1'b0;
    check("run_enable_cycles", 64'(en_total - s_en), 20);
    check("run_busy", 64'(busy_total - s_busy), 21);
    check("run_no_writes", 64'(wen_total - s_wen), 0);

    // Start pulsed mid-run with other parameters has no effect.
    snap();
    start_session(10'd0, 32'd20, 11'd0);
    repeat (5) tick();
    prog_len = 10'd3; run_cycles = 32'd7; dump_len = 11'd2;
    start = 1'b1;
    tick();
    start = 1'b0;
    wait_idle(1'b0, 100);
    check("ignored_start_enable", 64'(en_total - s_en), 20);
    check("ignored_start_done", 64'(done_total - s_done), 1);
    check("ignored_start_busy", 64'(busy_total - s_busy), 21);

    // Two-word dump with 5 cycles of backpressure on the first word.
    snap();
    dmem[0] = 32'hC; dmem[1] = 32'h3;
    dump_q.push_back(32'hC); dump_q.push_back(32'h3);
    out_ready = 1'b0;
    start_session(10'd0, 0, 11'd2);
    for (int n = 0; n < 20; n++) begin
      @(negedge clk);
      if (out_valid) break;
      tick();
    end
    check("dump_valid_seen", 64'(out_valid), 1);
    repeat (5) tick();
    out_ready = 1'b1;
    wait_idle(1'b0, 100);
    check("dump_handshakes", 64'(hs_total - s_hs), 2);
    check("dump_done", 64'(done_total - s_done), 1);
    check("dump_busy", 64'(busy_total - s_busy), 12);
    check("dump_queue_drained", 64'(dump_q.size()), 0);

    // All-zero session goes IDLE->DONE->IDLE.
    snap();
    start_session(10'd0, 0, 11'd0);
    wait_idle(1'b0, 20);
    check("zero_busy", 64'(busy_total - s_busy), 1);
    check("zero_done", 64'(done_total - s_done), 1);
    check("zero_strobes", 64'(wen_total - s_wen + en_total - s_en), 0);

    // Reset after the first of three words, with the second word offered.
    snap();
    load_words(3);
    start_session(10'd3, 0, 11'd0);
    feed(words[0]);
    in_valid = 1'b1; in_data = words[1];
    rst = 1'b1;
    tick();
    rst = 1'b0; in_valid = 1'b0;
    @(negedge clk);
    check("post_reset_outs", 64'(outs_vec()), 0);
    check("partial_load_writes", 64'(wen_total - s_wen), 1);
    wr_q.delete();
    tick();
    load_words(3);
    start_session(10'd3, 0, 11'd0);
    for (int i = 0; i < 3; i++) feed(words[i]);
    wait_idle(1'b0, 100);
    check("reload_queue_drained", 64'(wr_q.size()), 0);
`ifdef LOADER_CHECKSUM_EN
    check("reload_checksum", 64'(checksum), 64'(csum_model));
`endif

    // Full session with random words and random output backpressure.
    snap();
    csum_model = 0;
    for (int i = 0; i < 4; i++) begin
      rw[i] = $urandom;
      dmem[i] = $urandom;
      wr_q.push_back({32'(i * 4), rw[i]});
      dump_q.push_back(dmem[i]);
      csum_model += rw[i];
    end
    start_session(10'd4, 32'd5, 11'd4);
    for (int i = 0; i < 4; i++) feed(rw[i]);
    wait_idle(1'b1, 300);
    out_ready = 1'b1;
    check("full_enable_cycles", 64'(en_total - s_en), 5);
    check("full_handshakes", 64'(hs_total - s_hs), 4);
    check("full_done", 64'(done_total - s_done), 1);
    check("full_queues_drained", 64'(wr_q.size() + dump_q.size()), 0);
`ifdef LOADER_CHECKSUM_EN
    check("full_checksum", 64'(checksum), 64'(csum_model));
`endif
    repeat (3) tick();
  endtask

  initial begin
    fork
      monitor();
      stimulus();
      begin
        #200000;
        check("global_timeout", 1, 0);
      end
    join_any
    disable fork;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
